// File: rtl/dest_tag_pipe.sv
// Destination-tag pipeline: carries write tags through EX/MEM/WB for forwarding and
// register-file write-back, and raises a one-cycle load-use stall with an EX bubble.
module dest_tag_pipe #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] AwID,
  input  logic             RegWriteID,
  input  logic             MemReadID,
  input  logic [REG_W-1:0] AaID,
  input  logic [REG_W-1:0] AbID,
  input  logic             useAID,
  input  logic             useBID,
  input  logic             flushEX,
  output logic [REG_W-1:0] AwEX,
  output logic [REG_W-1:0] AwMEM,
  output logic [REG_W-1:0] AwWB,
  output logic             RegWriteWB,
  output logic             memReadEX,
  output logic             stall,
  output logic [CNT_W-1:0] stallCount
);

  localparam logic [REG_W-1:0] LP_ZERO = REG_W'(ZERO_REG);

  logic [REG_W-1:0] r_ex_aw, r_mem_aw, r_wb_aw;
  logic             r_ex_rw, r_mem_rw, r_wb_rw;
  logic             r_ex_mr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_ex_live;
  logic             w_hit_a, w_hit_b;
  logic             w_stall;
  logic             w_bubble;

  // MemRead only matters in EX (hazard source); later slots carry tag and write enable.
  always_comb begin
    w_ex_live = r_ex_mr && r_ex_rw && (r_ex_aw != LP_ZERO);
    w_hit_a   = useAID && (AaID == r_ex_aw);
    w_hit_b   = useBID && (AbID == r_ex_aw);
    w_stall   = reset && w_ex_live && (w_hit_a || w_hit_b);
    w_bubble  = flushEX || w_stall;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex_aw  <= LP_ZERO;
      r_ex_rw  <= 1'b0;
      r_ex_mr  <= 1'b0;
      r_mem_aw <= LP_ZERO;
      r_mem_rw <= 1'b0;
      r_wb_aw  <= LP_ZERO;
      r_wb_rw  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_mem_aw <= r_ex_aw;
      r_mem_rw <= r_ex_rw;
      r_wb_aw  <= r_mem_aw;
      r_wb_rw  <= r_mem_rw;
      if (w_bubble) begin
        r_ex_aw <= LP_ZERO;
        r_ex_rw <= 1'b0;
        r_ex_mr <= 1'b0;
      end else begin
        r_ex_aw <= AwID;
        r_ex_rw <= RegWriteID;
        r_ex_mr <= MemReadID;
      end
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    AwEX       = (r_ex_rw  && (r_ex_aw  != LP_ZERO)) ? r_ex_aw  : LP_ZERO;
    AwMEM      = (r_mem_rw && (r_mem_aw != LP_ZERO)) ? r_mem_aw : LP_ZERO;
    AwWB       = (r_wb_rw  && (r_wb_aw  != LP_ZERO)) ? r_wb_aw  : LP_ZERO;
    RegWriteWB = r_wb_rw && (r_wb_aw != LP_ZERO);
    memReadEX  = r_ex_mr;
    stall      = w_stall;
    stallCount = r_cnt;
  end

endmodule

// File: tb/tb_dest_tag_pipe.sv
// Bench for dest_tag_pipe: directed vector table, saturation sequence on a narrow
// counter instance, and randomized traffic against a slot-array reference model.
module tb_dest_tag_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] AwID, AaID, AbID;
  logic       RegWriteID, MemReadID, useAID, useBID, flushEX;
  logic [4:0] AwEX, AwMEM, AwWB;
  logic       RegWriteWB, memReadEX, stall;
  logic [15:0] stallCount;
  logic [4:0] AwEX2, AwMEM2, AwWB2;
  logic       RegWriteWB2, memReadEX2, stall2;
  logic [1:0] stallCount2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dest_tag_pipe dut (
    .clk(clk), .reset(reset), .AwID(AwID), .RegWriteID(RegWriteID), .MemReadID(MemReadID),
    .AaID(AaID), .AbID(AbID), .useAID(useAID), .useBID(useBID), .flushEX(flushEX),
    .AwEX(AwEX), .AwMEM(AwMEM), .AwWB(AwWB), .RegWriteWB(RegWriteWB),
    .memReadEX(memReadEX), .stall(stall), .stallCount(stallCount)
  );

  dest_tag_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .AwID(AwID), .RegWriteID(RegWriteID), .MemReadID(MemReadID),
    .AaID(AaID), .AbID(AbID), .useAID(useAID), .useBID(useBID), .flushEX(flushEX),
    .AwEX(AwEX2), .AwMEM(AwMEM2), .AwWB(AwWB2), .RegWriteWB(RegWriteWB2),
    .memReadEX(memReadEX2), .stall(stall2), .stallCount(stallCount2)
  );

  // Reference model: slot 0 = EX, 1 = MEM, 2 = WB.
  int m_aw[3];
  int m_rw[3];
  int m_mr[3];
  int m_cnt;
  int m_stall;
  int s_stall;

  function automatic int eff(int i);
    return (m_rw[i] != 0 && m_aw[i] != 31) ? m_aw[i] : 31;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one decode cycle, sample stall mid-cycle, clock it, advance the model.
  task automatic step(input bit rst, input int aw, input bit rw, input bit mr,
                      input int aa, input int ab, input bit ua, input bit ub, input bit fl);
    reset = rst; AwID = 5'(aw); RegWriteID = rw; MemReadID = mr;
    AaID = 5'(aa); AbID = 5'(ab); useAID = ua; useBID = ub; flushEX = fl;
    #1;
    s_stall = int'(stall);
    m_stall = (rst && m_mr[0] != 0 && m_rw[0] != 0 && m_aw[0] != 31 &&
               ((ua && aa == m_aw[0]) || (ub && ab == m_aw[0]))) ? 1 : 0;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin m_aw[i] = 31; m_rw[i] = 0; m_mr[i] = 0; end
      m_cnt = 0;
    end else begin
      if (m_stall != 0 && m_cnt < 65535) m_cnt++;
      for (int i = 2; i > 0; i--) begin
        m_aw[i] = m_aw[i-1]; m_rw[i] = m_rw[i-1]; m_mr[i] = m_mr[i-1];
      end
      if (fl || m_stall != 0) begin
        m_aw[0] = 31; m_rw[0] = 0; m_mr[0] = 0;
      end else begin
        m_aw[0] = aw; m_rw[0] = rw; m_mr[0] = mr;
      end
    end
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_stall"}, s_stall, m_stall);
    chk({tag, "_AwEX"}, int'(AwEX), eff(0));
    chk({tag, "_AwMEM"}, int'(AwMEM), eff(1));
    chk({tag, "_AwWB"}, int'(AwWB), eff(2));
    chk({tag, "_RegWriteWB"}, int'(RegWriteWB), (eff(2) != 31) ? 1 : 0);
    chk({tag, "_memReadEX"}, int'(memReadEX), m_mr[0]);
    chk({tag, "_stallCount"}, int'(stallCount), m_cnt);
    chk({tag, "_stallCount2"}, int'(stallCount2), (m_cnt > 3) ? 3 : m_cnt);
  endtask

  typedef struct {
    bit rst; int aw; bit rw; bit mr; int aa; int ab; bit ua; bit ub; bit fl;
    bit e_st; int e_ex; int e_mem; int e_wb; bit e_rwb; bit e_mrx; int e_cnt;
  } vec_t;

  vec_t tbl[23];

  initial begin
    for (int i = 0; i < 3; i++) begin m_aw[i] = 31; m_rw[i] = 0; m_mr[i] = 0; end
    m_cnt = 0;
    reset = 1'b0; AwID = '0; RegWriteID = 1'b0; MemReadID = 1'b0;
    AaID = '0; AbID = '0; useAID = 1'b0; useBID = 1'b0; flushEX = 1'b0;

    //         rst aw rw mr aa ab ua ub fl | st ex mem wb rwb mrx cnt
    tbl[0]  = '{1,  3, 1, 0, 0, 0, 0, 0, 0,  0, 3, 31, 31, 0, 0, 0};
    tbl[1]  = '{1, 31, 0, 0, 0, 0, 0, 0, 0,  0, 31, 3, 31, 0, 0, 0};
    tbl[2]  = '{1, 31, 0, 0, 0, 0, 0, 0, 0,  0, 31, 31, 3, 1, 0, 0};
    tbl[3]  = '{1,  5, 1, 1, 0, 0, 0, 0, 0,  0, 5, 31, 31, 0, 1, 0};
    tbl[4]  = '{1,  6, 1, 0, 5, 0, 1, 0, 0,  1, 31, 5, 31, 0, 0, 1};
    tbl[5]  = '{1,  6, 1, 0, 5, 0, 1, 0, 0,  0, 6, 31, 5, 1, 0, 1};
    tbl[6]  = '{1,  5, 1, 1, 0, 0, 0, 0, 0,  0, 5, 6, 31, 0, 1, 1};
    tbl[7]  = '{1,  8, 1, 0, 5, 0, 0, 0, 0,  0, 8, 5, 6, 1, 0, 1};
    tbl[8]  = '{1, 31, 1, 1, 0, 0, 0, 0, 0,  0, 31, 8, 5, 1, 1, 1};
    tbl[9]  = '{1,  9, 1, 0, 31, 31, 1, 1, 0, 0, 9, 31, 8, 1, 0, 1};
    tbl[10] = '{1,  7, 1, 0, 0, 0, 0, 0, 1,  0, 31, 9, 31, 0, 0, 1};
    tbl[11] = '{1, 31, 0, 0, 0, 0, 0, 0, 0,  0, 31, 31, 9, 1, 0, 1};
    tbl[12] = '{1, 31, 0, 0, 0, 0, 0, 0, 0,  0, 31, 31, 31, 0, 0, 1};
    tbl[13] = '{1,  4, 1, 1, 0, 0, 0, 0, 0,  0, 4, 31, 31, 0, 1, 1};
    tbl[14] = '{1, 10, 1, 0, 0, 4, 0, 1, 1,  1, 31, 4, 31, 0, 0, 2};
    tbl[15] = '{1, 10, 1, 0, 0, 4, 0, 1, 0,  0, 10, 31, 4, 1, 0, 2};
    tbl[16] = '{1, 12, 1, 1, 0, 0, 0, 0, 0,  0, 12, 10, 31, 0, 1, 2};
    tbl[17] = '{1, 13, 1, 0, 12, 0, 1, 0, 0, 1, 31, 12, 10, 1, 0, 3};
    tbl[18] = '{1, 14, 1, 1, 0, 0, 0, 0, 0,  0, 14, 31, 12, 1, 1, 3};
    tbl[19] = '{1, 15, 1, 0, 0, 0, 0, 0, 0,  0, 15, 14, 31, 0, 0, 3};
    tbl[20] = '{1, 16, 1, 1, 0, 0, 0, 0, 0,  0, 16, 15, 14, 1, 1, 3};
    tbl[21] = '{0, 17, 1, 1, 16, 0, 1, 0, 0, 0, 31, 31, 31, 0, 0, 0};
    tbl[22] = '{1, 31, 0, 0, 0, 0, 0, 0, 0,  0, 31, 31, 31, 0, 0, 0};

    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp_model("reset");

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].rst, tbl[i].aw, tbl[i].rw, tbl[i].mr, tbl[i].aa, tbl[i].ab,
           tbl[i].ua, tbl[i].ub, tbl[i].fl);
      chk($sformatf("v%0d_stall", i), s_stall, int'(tbl[i].e_st));
      chk($sformatf("v%0d_AwEX", i), int'(AwEX), tbl[i].e_ex);
      chk($sformatf("v%0d_AwMEM", i), int'(AwMEM), tbl[i].e_mem);
      chk($sformatf("v%0d_AwWB", i), int'(AwWB), tbl[i].e_wb);
      chk($sformatf("v%0d_RegWriteWB", i), int'(RegWriteWB), int'(tbl[i].e_rwb));
      chk($sformatf("v%0d_memReadEX", i), int'(memReadEX), int'(tbl[i].e_mrx));
      chk($sformatf("v%0d_stallCount", i), int'(stallCount), tbl[i].e_cnt);
      chk($sformatf("v%0d_stallCount2", i), int'(stallCount2),
          (tbl[i].e_cnt > 3) ? 3 : tbl[i].e_cnt);
    end

    // Five load-use hazards back to back: narrow counter must hold at 3.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 5, 1, 1, 0, 0, 0, 0, 0);
      cmp_model("sat_ld");
      step(1, 6, 1, 0, 5, 0, 1, 0, 0);
      cmp_model("sat_use");
    end
    chk("sat_stallCount", int'(stallCount), 5);
    chk("sat_stallCount2", int'(stallCount2), 3);

    for (int n = 0; n < 400; n++) begin
      int  aw, aa, ab;
      bit  rw, mr, ua, ub, fl, rst;
      aw  = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 3));
      aa  = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 3));
      ab  = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 3));
      rw  = ($urandom_range(0, 3) != 0);
      mr  = ($urandom_range(0, 1) != 0);
      ua  = ($urandom_range(0, 2) != 0);
      ub  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 39) != 0);
      step(rst, aw, rw, mr, aa, ab, ua, ub, fl);
      cmp_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dest_tag_pipe.md
Name: dest_tag_pipe

Overview:
- Tracks destination-register tags and write/load qualifiers for each instruction as it moves from decode through EX, MEM and WB.
- Supplies the EX/MEM write addresses that the forwarding unit compares against register-fetch source addresses.
- Detects load-use hazards, requests a one-cycle stall, and inserts a bubble into EX.
- Sits between the decode stage and the forwarding unit / register-file write port.

Parameters:
- REG_W, 5, register address width.
- ZERO_REG, 31, XZR address; presented by any slot that does not write.
- CNT_W, 16, width of the stall event counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- AwID  input  REG_W  destination register of the instruction in decode.
- RegWriteID  input  1  decode instruction writes the register file.
- MemReadID  input  1  decode instruction is a load.
- AaID  input  REG_W  decode source A address.
- AbID  input  REG_W  decode source B address.
- useAID  input  1  source A is actually read.
- useBID  input  1  source B is actually read.
- flushEX  input  1  taken branch; squash the instruction entering EX.
- AwEX  output  REG_W  EX-stage effective write address.
- AwMEM  output  REG_W  MEM-stage effective write address.
- AwWB  output  REG_W  WB-stage effective write address.
- RegWriteWB  output  1  register-file write enable.
- memReadEX  output  1  EX-stage instruction is a load.
- stall  output  1  freeze PC and IF/ID register this cycle.
- stallCount  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low.
- Stage registers: three slots (EX, MEM, WB), each holding {Aw, RegWrite, MemRead}, updated on the rising edge of clk.
- Effective address:
  - Output Aw = stored Aw if RegWrite=1 and Aw!=ZERO_REG, else ZERO_REG.
  - A non-writing slot therefore never matches a real source register.
- Advance: MEM<=EX and WB<=MEM every cycle, unconditionally; stall never freezes EX/MEM/WB.
- EX load rule:
  - EX<=bubble {ZERO_REG,0,0} when flushEX=1 or stall=1.
  - Otherwise EX<={AwID, RegWriteID, MemReadID}.
  - flushEX and stall together: bubble, loaded once.
- stall is combinational (0 cycles of latency) and asserts when all of:
  - EX MemRead=1,
  - EX RegWrite=1,
  - EX Aw!=ZERO_REG,
  - (useAID & AaID==EX Aw) | (useBID & AbID==EX Aw).
- stall deasserts the cycle after the bubble enters EX.
  - The held decode instruction re-presents and sees the load in MEM, where the forwarding unit resolves it.
  - Maximum stall length per hazard is 1 cycle.
- Source address ZERO_REG never causes a stall, because EX Aw!=ZERO_REG is required.
- memReadEX = EX MemRead.
- RegWriteWB = WB RegWrite & (WB Aw!=ZERO_REG).
- stallCount: +1 on each rising edge with stall=1; saturates at 2^CNT_W-1; no wrap.
- Reset (reset=0 at a rising edge), including mid-operation:
  - All slots become bubbles; stallCount<=0.
  - Outputs next cycle: AwEX=AwMEM=AwWB=ZERO_REG, RegWriteWB=0, memReadEX=0, stall=0, stallCount=0.
  - Inputs are ignored while reset=0.

Test Plan:
1. Reset release, then ALU op AwID=3, RegWriteID=1 -> AwEX=3 after 1 edge, AwMEM=3 after 2, AwWB=3 with RegWriteWB=1 after 3; no stall.
2. Load AwID=5 (MemReadID=1), next decode reads AaID=5 with useAID=1 -> stall=1 for exactly one cycle; next edge AwEX=31 and AwMEM=5; stallCount=1.
3. Load to X5 followed by a consumer with useAID=0 and AaID=5 -> stall=0; also a load writing X31 followed by a reader of X31 -> stall=0.
4. flushEX=1 while decode holds AwID=7, RegWriteID=1 -> AwEX=31 next cycle; X7 never reaches AwWB; RegWriteWB stays 0 for that slot.
5. flushEX=1 coincident with a load-use stall -> single bubble in EX; stall drops next cycle; stallCount increments by 1.
6. reset=0 asserted with valid tags in all three stages -> next edge all Aw outputs=31, stall=0, stallCount=0. Separately, with CNT_W forced to 2, drive 5 stall cycles -> stallCount holds at 3.
